// File: rtl/ex_muldiv_unit.sv
// Execute-stage MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Multiplies complete in one cycle; divides run a restoring loop, then a sign-fix cycle.
module ex_muldiv_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

  state_t      r_state, w_next;
  logic [1:0]  r_op;
  logic [31:0] r_opa, r_opb, r_dvd, r_dvs, r_quo, r_hi, r_lo;
  logic [32:0] r_rem;
  logic [5:0]  r_cnt;
  logic        r_dz, r_done;

  logic [31:0] w_abs_a, w_abs_b, w_q_fix, w_r_fix, w_res_hi, w_res_lo;
  logic [32:0] w_rem_sh;
  logic [33:0] w_diff;
  logic [63:0] w_ea, w_eb, w_prod;
  logic        w_qbit, w_wr_res, w_accept, w_mt;

  assign w_abs_a  = (op[0] && opa[31]) ? -opa : opa;
  assign w_abs_b  = (op[0] && opb[31]) ? -opb : opb;
  assign w_rem_sh = {r_rem[31:0], r_dvd[31]};
  // One extra bit so a failed trial subtraction shows up as a negative result.
  assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_dvs};
  assign w_qbit   = ~w_diff[33];

  // Sign/zero-extend to 64 bits; the low 64 bits of the product are then correct for both.
  assign w_ea   = {{32{r_op[0] & r_opa[31]}}, r_opa};
  assign w_eb   = {{32{r_op[0] & r_opb[31]}}, r_opb};
  assign w_prod = w_ea * w_eb;

  assign w_q_fix = (r_op[0] && (r_opa[31] ^ r_opb[31])) ? -r_quo : r_quo;
  assign w_r_fix = (r_op[0] && r_opa[31]) ? -r_rem[31:0] : r_rem[31:0];

  always_comb begin
    w_next   = r_state;
    w_wr_res = 1'b0;
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    case (r_state)
      S_IDLE: if (start) w_next = !op[1] ? S_MUL : (opb == 32'd0) ? S_FIX : S_DIV;
      S_MUL: begin
        w_next   = S_IDLE;
        w_wr_res = 1'b1;
      end
      S_DIV: if (r_cnt == LAST_ITER) w_next = S_FIX;
      S_FIX: begin
        w_next   = S_IDLE;
        w_wr_res = 1'b1;
        w_res_hi = r_dz ? r_opa : w_r_fix;
        w_res_lo = r_dz ? 32'hFFFF_FFFF : w_q_fix;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush) begin
      w_next   = S_IDLE;
      w_wr_res = 1'b0;
    end
  end

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_mt     = (r_state == S_IDLE) && !start && !flush;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= '0; r_opa <= '0; r_opb <= '0; r_dvd <= '0; r_dvs <= '0;
      r_quo <= '0; r_rem <= '0; r_cnt <= '0; r_dz <= 1'b0;
      r_hi <= '0; r_lo <= '0; r_done <= 1'b0;
    end else begin
      r_done <= w_wr_res;
      if (w_wr_res) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_mt) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
      if (w_accept) begin
        r_op  <= op;
        r_opa <= opa;
        r_opb <= opb;
        r_dvd <= w_abs_a;
        r_dvs <= w_abs_b;
        r_rem <= '0;
        r_quo <= '0;
        r_cnt <= '0;
        r_dz  <= op[1] && (opb == 32'd0);
      end else if (r_state == S_DIV) begin
        r_rem <= w_qbit ? w_diff[32:0] : w_rem_sh;
        r_quo <= {r_quo[30:0], w_qbit};
        r_dvd <= r_dvd << 1;
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed spec vectors, randomized ops against
// an arithmetic reference, flush/reset aborts, busy-time interference and MTHI/MTLO.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] opa, opb, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  ex_muldiv_unit #(.DIV_ITERS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: results straight from the arithmetic definition of each op.
  function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el, output int lat);
    logic [63:0] p;
    if (!o[1]) begin
      if (o[0]) p = 64'($signed(a)) * 64'($signed(b));
      else      p = {32'd0, a} * {32'd0, b};
      eh = p[63:32]; el = p[31:0]; lat = 1;
    end else if (b == 0) begin
      eh = a; el = 32'hFFFF_FFFF; lat = 1;
    end else if (o[0]) begin
      lat = 33;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        el = 32'h8000_0000; eh = 32'd0;
      end else begin
        el = 32'($signed(a) / $signed(b));
        eh = 32'($signed(a) % $signed(b));
      end
    end else begin
      el = a / b; eh = a % b; lat = 33;
    end
  endfunction

  // Issue one op and wait for done; reports latency (edges from start to HI/LO write),
  // busy-cycle count and whether done lasted exactly one cycle.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcyc, output bit ok_pulse, output bit timeout);
    start = 1'b1; op = o; opa = a; opb = b;
    step();
    start = 1'b0; opa = $urandom; opb = $urandom;
    lat = 0; bcyc = 0; timeout = 1'b0; ok_pulse = 1'b0;
    while (!done) begin
      if (busy) bcyc++;
      if (lat >= 100) begin
        timeout = 1'b1;
        break;
      end
      step();
      lat++;
    end
    if (!timeout) begin
      step();
      ok_pulse = !done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; flush = 0; hi_we = 0; lo_we = 0; op = 0; opa = 0; opb = 0; wdata = 0;
    step(); step();
    rst = 1'b0;
    n_tests++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%0b done=%0b hi=%h lo=%h want all 0", busy, done, hi, lo);
    end
    // Reset in the middle of a divide: no done, registers back to zero.
    hi_we = 1; lo_we = 1; wdata = 32'h5555_AAAA; step(); hi_we = 0; lo_we = 0;
    start = 1; op = 2'b10; opa = 100; opb = 7; step(); start = 0;
    repeat (5) step();
    rst = 1; step(); rst = 0;
    n_tests++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%0b done=%0b hi=%h lo=%h want all 0", busy, done, hi, lo);
    end
    begin
      bit seen = 0;
      repeat (40) begin step(); if (done) seen = 1; end
      n_tests++;
      if (seen) begin n_fail++; $display("FAIL reset_no_done: done seen after reset abort, want none"); end
    end
  endtask

  task automatic test_directed();
    logic [1:0]  vo [8] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11};
    logic [31:0] va [8] = '{100, 32'hFFFF_FFF9, 7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234,
                            32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] vb [8] = '{7, 2, 32'hFFFF_FFFE, 2, 2, 0, 32'hFFFF_FFFF, 0};
    logic [31:0] wh [8] = '{2, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 32'h1234, 0, 32'hFFFF_FFF9};
    logic [31:0] wl [8] = '{14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                            32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    int wlat [8] = '{33, 33, 33, 1, 1, 1, 33, 1};
    int lat, bc; bit okp, to;
    for (int i = 0; i < 8; i++) begin
      issue(vo[i], va[i], vb[i], lat, bc, okp, to);
      n_tests++;
      if (to || hi !== wh[i] || lo !== wl[i] || lat != wlat[i] || bc != wlat[i] || !okp) begin
        n_fail++;
        $display("FAIL directed[%0d]: hi=%h lo=%h lat=%0d busy=%0d pulse_ok=%0b to=%0b want hi=%h lo=%h lat=busy=%0d",
                 i, hi, lo, lat, bc, okp, to, wh[i], wl[i], wlat[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, eh, el; logic [1:0] o; int elat, lat, bc; bit okp, to;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      ref_op(o, a, b, eh, el, elat);
      issue(o, a, b, lat, bc, okp, to);
      n_tests++;
      if (to || hi !== eh || lo !== el || lat != elat || !okp) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d to=%0b want hi=%h lo=%h lat=%0d",
                 i, o, a, b, hi, lo, lat, to, eh, el, elat);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] h0, l0, eh, el; int elat, lat, bc; bit okp, to, seen;
    issue(2'b00, 32'h0001_0003, 32'h0002_0005, lat, bc, okp, to);
    h0 = hi; l0 = lo;
    start = 1; op = 2'b11; opa = 32'hFFFF_0000; opb = 3; step(); start = 0;
    repeat (10) step();
    flush = 1; step(); flush = 0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== h0 || lo !== l0) begin
      n_fail++;
      $display("FAIL flush_abort: busy=%0b done=%0b hi=%h lo=%h want 0 0 %h %h", busy, done, hi, lo, h0, l0);
    end
    seen = 0;
    repeat (30) begin step(); if (done || hi !== h0 || lo !== l0) seen = 1; end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL flush_quiet: done or HI/LO change after flush, want none"); end
    ref_op(2'b11, 32'hFFFF_FF00, 32'h0000_0007, eh, el, elat);
    issue(2'b11, 32'hFFFF_FF00, 32'h0000_0007, lat, bc, okp, to);
    n_tests++;
    if (to || hi !== eh || lo !== el || lat != elat) begin
      n_fail++;
      $display("FAIL flush_restart: hi=%h lo=%h lat=%0d want %h %h %0d", hi, lo, lat, eh, el, elat);
    end
    // Flush and start together: start dropped.
    h0 = hi; l0 = lo;
    flush = 1; start = 1; op = 2'b00; opa = 5; opb = 6; step(); flush = 0; start = 0;
    n_tests++;
    if (busy !== 1'b0 || hi !== h0 || lo !== l0) begin
      n_fail++;
      $display("FAIL flush_start: busy=%0b hi=%h lo=%h want 0 %h %h", busy, hi, lo, h0, l0);
    end
    step();
    n_tests++;
    if (done !== 1'b0 || hi !== h0 || lo !== l0) begin
      n_fail++;
      $display("FAIL flush_start_late: done=%0b hi=%h lo=%h want 0 %h %h", done, hi, lo, h0, l0);
    end
  endtask

  task automatic test_busy_ignore();
    int n; bit to;
    start = 1; op = 2'b10; opa = 1000; opb = 9; step(); start = 0;
    repeat (4) step();
    start = 1; op = 2'b00; opa = 3; opb = 4; hi_we = 1; lo_we = 1; wdata = 32'hDEAD; step();
    start = 0; hi_we = 0; lo_we = 0;
    n = 5; to = 0;
    while (!done) begin
      step(); n++;
      if (n > 100) begin to = 1; break; end
    end
    n_tests++;
    if (to || hi !== 32'd1 || lo !== 32'd111 || n != 33) begin
      n_fail++;
      $display("FAIL busy_ignore: hi=%h lo=%h lat=%0d to=%0b want hi=1 lo=6f lat=33", hi, lo, n, to);
    end
    step();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore_idle: busy=%0b done=%0b want 0 0 (ignored start must not run)", busy, done);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] h0;
    hi_we = 1; wdata = 32'hDEAD; step(); hi_we = 0;
    n_tests++;
    if (hi !== 32'hDEAD || done !== 1'b0) begin
      n_fail++; $display("FAIL mthi: hi=%h done=%0b want dead 0", hi, done);
    end
    h0 = hi;
    lo_we = 1; wdata = 32'hBEEF_0001; step(); lo_we = 0;
    n_tests++;
    if (lo !== 32'hBEEF_0001 || hi !== h0) begin
      n_fail++; $display("FAIL mtlo: hi=%h lo=%h want %h beef0001", hi, lo, h0);
    end
    hi_we = 1; lo_we = 1; wdata = 32'h0C0F_FEE0; step(); hi_we = 0; lo_we = 0;
    n_tests++;
    if (hi !== 32'h0C0F_FEE0 || lo !== 32'h0C0F_FEE0) begin
      n_fail++; $display("FAIL mt_both: hi=%h lo=%h want 0c0ffee0 both", hi, lo);
    end
    // Start in the same cycle as a write: write dropped, HI/LO untouched until E1.
    start = 1; op = 2'b00; opa = 3; opb = 5; hi_we = 1; lo_we = 1; wdata = 32'h1111_2222; step();
    start = 0; hi_we = 0; lo_we = 0;
    n_tests++;
    if (hi !== 32'h0C0F_FEE0 || lo !== 32'h0C0F_FEE0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mt_vs_start: hi=%h lo=%h busy=%0b want 0c0ffee0 0c0ffee0 1", hi, lo, busy);
    end
    step();
    n_tests++;
    if (hi !== 32'd0 || lo !== 32'd15 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mt_vs_start_res: hi=%h lo=%h done=%0b busy=%0b want 0 f 1 0", hi, lo, done, busy);
    end
    // Write while flushing in IDLE is dropped.
    flush = 1; hi_we = 1; wdata = 32'h7777; step(); flush = 0; hi_we = 0;
    n_tests++;
    if (hi !== 32'd0) begin
      n_fail++; $display("FAIL mt_vs_flush: hi=%h want 0", hi);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_busy_ignore();
    test_mthi_mtlo();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
